// File: rtl/mrsc_decoder.sv
// MRSC codeword decoder: syndrome stage (S1) then correction/status stage (S2), valid/ready on both sides.
// Optional saturating error counters are built only when MRSC_DEC_ERR_CNT_EN is defined.
module mrsc_decoder
`ifdef MRSC_DEC_ERR_CNT_EN
  #(parameter int unsigned CNT_W = 16)
`endif
(
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_word,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_data,
  output logic [1:0]       out_status
`ifdef MRSC_DEC_ERR_CNT_EN
  ,
  input  logic             err_clr,
  output logic [CNT_W-1:0] corr_cnt,
  output logic [CNT_W-1:0] uncorr_cnt
`endif
);

  logic        s1_valid_q;
  logic [15:0] s1_data_q;
  logic [7:0]  s1_sx_q,  s1_sx_d;
  logic [3:0]  s1_sdi_q, s1_sdi_d;
  logic [3:0]  s1_sp_q,  s1_sp_d;

  logic        out_valid_q;
  logic [15:0] out_data_q, out_data_d;
  logic [1:0]  out_status_q, out_status_d;

  logic        s2_adv;
  logic        s1_load;
  logic [15:0] flip;
  logic [15:0] syn_all;

  assign s2_adv   = !out_valid_q || out_ready;
  assign in_ready = !s1_valid_q || s2_adv;
  assign s1_load  = in_valid && in_ready;

  // Syndromes: received redundancy XOR redundancy recomputed from received data
  always_comb begin
    s1_sx_d  = in_word[23:16];
    s1_sdi_d = in_word[27:24];
    s1_sp_d  = in_word[31:28];
    for (int unsigned n = 0; n < 4; n++) begin
      s1_sx_d[2*n]   = s1_sx_d[2*n]   ^ in_word[4*n]   ^ in_word[4*n+2];
      s1_sx_d[2*n+1] = s1_sx_d[2*n+1] ^ in_word[4*n+1] ^ in_word[4*n+3];
    end
    for (int unsigned k = 0; k < 4; k++) begin
      s1_sp_d[k]  = s1_sp_d[k] ^ in_word[k] ^ in_word[4+k] ^ in_word[8+k] ^ in_word[12+k];
      s1_sdi_d[k] = s1_sdi_d[k] ^ in_word[k] ^ in_word[4+(k^1)]
                    ^ in_word[8+k] ^ in_word[12+(k^1)];
    end
  end

  // Nibbles B and D pair with the diagonal of the neighbouring bit index
  always_comb begin
    flip    = '0;
    syn_all = {s1_sp_q, s1_sdi_q, s1_sx_q};
    for (int unsigned n = 0; n < 4; n++) begin
      for (int unsigned i = 0; i < 4; i++) begin
        flip[4*n+i] = s1_sx_q[2*n+(i%2)]
                      && (s1_sp_q[i] || s1_sdi_q[(n%2 == 0) ? i : (i^1)]);
      end
    end
    out_data_d   = s1_data_q;
    out_status_d = 2'b11;
    if (syn_all == '0) begin
      out_status_d = 2'b00;
    end else if (flip != '0) begin
      out_data_d   = s1_data_q ^ flip;
      out_status_d = 2'b01;
    end else if ((syn_all & (syn_all - 16'd1)) == '0) begin
      out_status_d = 2'b10;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q   <= 1'b0;
      s1_data_q    <= '0;
      s1_sx_q      <= '0;
      s1_sdi_q     <= '0;
      s1_sp_q      <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_status_q <= '0;
    end else begin
      if (in_ready) begin
        s1_valid_q <= in_valid;
      end
      if (s1_load) begin
        s1_data_q <= in_word[15:0];
        s1_sx_q   <= s1_sx_d;
        s1_sdi_q  <= s1_sdi_d;
        s1_sp_q   <= s1_sp_d;
      end
      if (s2_adv) begin
        out_valid_q <= s1_valid_q;
      end
      if (s2_adv && s1_valid_q) begin
        out_data_q   <= out_data_d;
        out_status_q <= out_status_d;
      end
    end
  end

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_status = out_status_q;

`ifdef MRSC_DEC_ERR_CNT_EN
  logic             out_xfer;
  logic [CNT_W-1:0] corr_cnt_q,   corr_cnt_d;
  logic [CNT_W-1:0] uncorr_cnt_q, uncorr_cnt_d;

  assign out_xfer = out_valid_q && out_ready;

  // err_clr overrides any increment in the same cycle
  always_comb begin
    corr_cnt_d   = corr_cnt_q;
    uncorr_cnt_d = uncorr_cnt_q;
    if (err_clr) begin
      corr_cnt_d   = '0;
      uncorr_cnt_d = '0;
    end else if (out_xfer) begin
      if (out_status_q == 2'b01 && corr_cnt_q != '1) begin
        corr_cnt_d = corr_cnt_q + CNT_W'(1);
      end
      if (out_status_q == 2'b11 && uncorr_cnt_q != '1) begin
        uncorr_cnt_d = uncorr_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      corr_cnt_q   <= '0;
      uncorr_cnt_q <= '0;
    end else begin
      corr_cnt_q   <= corr_cnt_d;
      uncorr_cnt_q <= uncorr_cnt_d;
    end
  end

  assign corr_cnt   = corr_cnt_q;
  assign uncorr_cnt = uncorr_cnt_q;
`endif

endmodule

// File: tb/tb_mrsc_decoder.sv
// Scoreboard bench for mrsc_decoder: driver queues model results, monitor checks every output transfer.
module tb_mrsc_decoder;

  typedef struct packed {
    logic [15:0] d;
    logic [1:0]  s;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_word = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] out_data;
  logic [1:0]  out_status;
`ifdef MRSC_DEC_ERR_CNT_EN
  localparam int unsigned CW = 2;
  logic          err_clr = 1'b0;
  logic [CW-1:0] corr_cnt, uncorr_cnt;
  int            m_corr, m_uncorr;
`endif

  int   checks = 0;
  int   errors = 0;
  exp_t q[$];
  bit   rand_rdy = 1'b0;
  int   inready_lows = 0;

`ifdef MRSC_DEC_ERR_CNT_EN
  mrsc_decoder #(.CNT_W(CW)) dut (
`else
  mrsc_decoder dut (
`endif
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_word(in_word),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_status(out_status)
`ifdef MRSC_DEC_ERR_CNT_EN
    , .err_clr(err_clr), .corr_cnt(corr_cnt), .uncorr_cnt(uncorr_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  function automatic exp_t mk(input logic [15:0] d, input logic [1:0] s);
    exp_t e;
    e.d = d;
    e.s = s;
    return e;
  endfunction

  // Redundancy {P4..P1, DI_4..DI_1, X[7:0]} from the encoding equations
  function automatic logic [15:0] red_of(input logic [15:0] d);
    logic [3:0] nib [4];
    logic [7:0] x;
    logic [3:0] p, di;
    for (int n = 0; n < 4; n++) nib[n] = d[4*n +: 4];
    for (int n = 0; n < 4; n++) begin
      x[2*n]   = nib[n][0] ^ nib[n][2];
      x[2*n+1] = nib[n][1] ^ nib[n][3];
    end
    for (int k = 0; k < 4; k++) begin
      p[k]  = nib[0][k] ^ nib[1][k] ^ nib[2][k] ^ nib[3][k];
      di[k] = nib[0][k] ^ nib[1][k^1] ^ nib[2][k] ^ nib[3][k^1];
    end
    return {p, di, x};
  endfunction

  function automatic exp_t model(input logic [31:0] w);
    logic [15:0] syn, flips;
    logic [7:0]  sx;
    logic [3:0]  sdi, sp;
    int          nset;
    syn   = w[31:16] ^ red_of(w[15:0]);
    sx    = syn[7:0];
    sdi   = syn[11:8];
    sp    = syn[15:12];
    flips = '0;
    for (int b = 0; b < 16; b++) begin
      int n, i, j;
      n = b / 4;
      i = b % 4;
      j = (n == 0 || n == 2) ? i : (i ^ 1);
      if (sx[2*n + i%2] && (sp[i] || sdi[j])) flips[b] = 1'b1;
    end
    nset = $countones(syn);
    if (nset == 0)       return mk(w[15:0], 2'b00);
    else if (flips != 0) return mk(w[15:0] ^ flips, 2'b01);
    else if (nset == 1)  return mk(w[15:0], 2'b10);
    else                 return mk(w[15:0], 2'b11);
  endfunction

  function automatic logic [31:0] gen_word(input int max_err);
    logic [15:0] d;
    logic [31:0] w;
    d = 16'($urandom);
    w = {red_of(d), d};
    repeat ($urandom_range(0, max_err)) w = w ^ (32'd1 << $urandom_range(0, 31));
    return w;
  endfunction

  // Leaves in_valid high so consecutive calls stream back-to-back
  task automatic send(input logic [31:0] w, input exp_t e);
    int t = 0;
    in_word  = w;
    in_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (in_ready) begin
        q.push_back(e);
        @(posedge clk); #1;
        break;
      end
      @(posedge clk); #1;
      t++;
      if (t > 100) begin
        checks++; errors++;
        $display("FAIL send_timeout: in_ready stuck 0, word %h", w);
        break;
      end
    end
  endtask

  task automatic drain();
    int t = 0;
    in_valid = 1'b0;
    while (q.size() != 0 && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    chk("drain_empty", q.size(), 0);
    repeat (2) begin @(posedge clk); #1; end
  endtask

  // Monitor: in_ready rule, output hold under stall, and scoreboard compare
  initial begin
    int   acc = 0, pops = 0, occ;
    bit   stall = 1'b0;
    logic [15:0] hd;
    logic [1:0]  hs;
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        acc = 0; pops = 0; stall = 1'b0;
`ifdef MRSC_DEC_ERR_CNT_EN
        m_corr = 0; m_uncorr = 0;
`endif
      end else begin
        occ = acc - pops;
        chk("in_ready", in_ready, !(out_valid && !out_ready && occ == 2));
        if (!in_ready) inready_lows++;
        if (stall) begin
          chk("hold_valid", out_valid, 1);
          chk("hold_data", out_data, hd);
          chk("hold_status", out_status, hs);
        end
`ifdef MRSC_DEC_ERR_CNT_EN
        chk("corr_cnt", corr_cnt, m_corr);
        chk("uncorr_cnt", uncorr_cnt, m_uncorr);
`endif
        if (out_valid && out_ready) begin
          if (q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_output: data %h status %b", out_data, out_status);
          end else begin
            e = q.pop_front();
            chk("out_data", out_data, e.d);
            chk("out_status", out_status, e.s);
            pops++;
`ifdef MRSC_DEC_ERR_CNT_EN
            if (e.s == 2'b01 && m_corr < (1 << CW) - 1) m_corr++;
            if (e.s == 2'b11 && m_uncorr < (1 << CW) - 1) m_uncorr++;
`endif
          end
        end
`ifdef MRSC_DEC_ERR_CNT_EN
        if (err_clr) begin m_corr = 0; m_uncorr = 0; end
`endif
        stall = out_valid && !out_ready;
        hd = out_data;
        hs = out_status;
        if (in_valid && in_ready) acc++;
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int lows0;
    logic [31:0] w1, w2;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_status", out_status, 0);
    chk("rst_in_ready", in_ready, 1);

    send(32'h0000FFFF, mk(16'hFFFF, 2'b00));
    send(32'h00000001, mk(16'h0000, 2'b01));
    send(32'h00000003, mk(16'h0000, 2'b01));
    send(32'h00010000, mk(16'h0000, 2'b10));
    send(32'h00000005, mk(16'h0005, 2'b11));
    drain();

    // Two-cycle latency from an empty pipeline
    send(32'h0000FFFF, mk(16'hFFFF, 2'b00));
    in_valid = 1'b0;
    chk("lat_n_plus_1", out_valid, 0);
    @(posedge clk); #1;
    chk("lat_n_plus_2", out_valid, 1);
    drain();

    lows0 = inready_lows;
    fork
      begin
        for (int k = 0; k < 8; k++) begin
          w1 = gen_word(3);
          send(w1, model(w1));
        end
        in_valid = 1'b0;
      end
      begin
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();
    chk("stream_in_ready_dropped", inready_lows > lows0, 1);

    // Reset with both stages occupied
    out_ready = 1'b0;
    w1 = {red_of(16'h1234), 16'h1234};
    w2 = {red_of(16'hBEEF), 16'hBEEF};
    send(w1, model(w1));
    send(w2, model(w2));
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_out_data", out_data, 0);
    chk("midrst_out_status", out_status, 0);
    q.delete();
    rst = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("postrst_in_ready", in_ready, 1);
    chk("postrst_out_valid", out_valid, 0);
    repeat (4) begin @(posedge clk); #1; end

    rand_rdy = 1'b1;
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        @(posedge clk); #1;
      end else begin
        w1 = gen_word(3);
        send(w1, model(w1));
      end
    end
    in_valid = 1'b0;
    rand_rdy = 1'b0;
    @(posedge clk); #2;
    out_ready = 1'b1;
    drain();

`ifdef MRSC_DEC_ERR_CNT_EN
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
    chk("cnt_cleared", corr_cnt, 0);
    for (int k = 0; k < 5; k++) begin
      w1 = {16'h0, 16'($urandom)};
      w1 = {red_of(w1[15:0]), w1[15:0]} ^ (32'd1 << $urandom_range(0, 15));
      send(w1, model(w1));
    end
    drain();
    chk("corr_saturated", corr_cnt, 3);
    w1 = {red_of(16'h0F0F), 16'h0F0F} ^ 32'h5;
    err_clr = 1'b1;
    send(w1, mk(16'h0F0A, 2'b11));
    drain();
    err_clr = 1'b0;
    @(posedge clk); #1;
    chk("uncorr_clr_priority", uncorr_cnt, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mrsc_decoder.md
Name: mrsc_decoder

Overview:
- Pipelined decoder for the 32-bit MRSC codeword produced by the team's MRSC encoder.
- Recomputes the check, diagonal and parity syndromes and corrects data bits by MRSC region selection.
- Returns the 16-bit data word plus a 2-bit status.
- Sits on the read side of protected storage. Valid/ready handshake on both sides, 2-stage pipeline.

Parameters:
CNT_W, 16, width of the saturating error counters (optional feature only)

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
in_valid  input  1  codeword valid
in_ready  output  1  decoder can accept a codeword
in_word  input  32  encoded word: [15:0] data; [23:16] X bits; [27:24] DI_4..DI_1; [31:28] P4..P1
out_valid  output  1  result valid
out_ready  input  1  downstream accepts result
out_data  output  16  corrected data
out_status  output  2  00 clean, 01 data corrected, 10 redundancy-bit-only error, 11 uncorrectable
err_clr  input  1  clear counters (optional feature only)
corr_cnt  output  CNT_W  corrected-word count (optional feature only)
uncorr_cnt  output  CNT_W  uncorrectable-word count (optional feature only)

Behaviour:
- Interface: one clock `clk`, synchronous active-high reset `rst` (fixed).
- Data nibbles: A=[3:0], B=[7:4], C=[11:8], D=[15:12].
- X bits [23:16] = {XD_hi, XD_lo, XC_hi, XC_lo, XB_hi, XB_lo, XA_hi, XA_lo}, where N_lo = N[0]^N[2] and N_hi = N[1]^N[3].
- Encoding equations:
  - P(k+1) = A[k]^B[k]^C[k]^D[k].
  - DI_1 = A0^B1^C0^D1; DI_2 = A1^B0^C1^D0; DI_3 = A2^B3^C2^D3; DI_4 = A3^B2^C3^D2.
- Syndromes: sX[7:0], sDI[3:0] and sP[3:0] are each the received redundancy bit XOR the value recomputed from received data.
- Stage 1 (S1) registers the data, sX, sDI and sP.
- Stage 2 (S2) registers the corrected data and status.
- Correction rule for data bit N[i]:
  - Flip if sX[N, i mod 2] && (sP[i] || sDI[j]).
  - j = i for nibbles A and C; j = i^1 for nibbles B and D.
- Status:
  - 00 if all 16 syndrome bits are zero.
  - 01 if at least one flip occurred.
  - 10 if no flip and exactly one syndrome bit is set.
  - 11 otherwise.
  - Status 11: out_data = received data, unmodified.
- Handshake:
  - A transfer occurs on a cycle where valid && ready.
  - S2 advances when !out_valid || out_ready.
  - S1 advances into S2 when S2 advances.
  - in_ready = !s1_valid || S2 advances (combinational from out_ready; no skid buffer).
- Latency and throughput:
  - With out_ready held high, a word accepted in cycle N appears with out_valid=1 in cycle N+2.
  - Throughput is 1 word/cycle.
- Backpressure:
  - While out_valid && !out_ready, out_data and out_status are held stable.
  - Once S1 is also full, in_ready=0.
  - No word is dropped or duplicated.
- Simultaneous events: in the same cycle, acceptance into S1, the S1->S2 move and output consumption are all legal.
- Reset:
  - out_valid=0, out_data=0, out_status=00, internal valids=0.
  - in_ready=1 in the cycle after reset deasserts.
  - Reset mid-transfer discards all in-flight words.
- Data registers are loaded only on their advance enable.

Optional Feature:
- Macro: MRSC_DEC_ERR_CNT_EN.
- Defined:
  - corr_cnt increments on each output transfer with status 01.
  - uncorr_cnt increments on each output transfer with status 11.
  - Both saturate at 2^CNT_W-1 (no wrap).
  - err_clr zeroes both counters next cycle; it has priority over a same-cycle increment.
  - rst zeroes both counters.
- Undefined: err_clr, corr_cnt and uncorr_cnt ports are absent; no counter logic is present.

Test Plan:
- in_word=32'h0000FFFF, out_ready=1 -> 2 cycles later out_data=16'hFFFF, status 00.
- in_word=32'h00000001 (A0 flip) -> out_data=16'h0000, status 01; in_word=32'h00000003 (A0, A1) -> out_data=16'h0000, status 01.
- in_word=32'h00010000 (XA_lo flip) -> out_data=16'h0000, status 10; in_word=32'h00000005 (A0, A2) -> out_data=16'h0005, status 11.
- Back-to-back stream of 8 words; out_ready=0 for 3 cycles mid-stream -> in_ready drops once S1 is full, output held stable, all 8 results delivered in order with no loss.
- rst asserted with both stages full -> next cycle out_valid=0, out_data=0, out_status=00; in_ready=1 after reset deasserts; the discarded words never appear.
- With MRSC_DEC_ERR_CNT_EN, CNT_W=2 -> 5 status-01 words give corr_cnt=3 (saturated); err_clr concurrent with a status-11 transfer gives uncorr_cnt=0.
